// File: rtl/ll_multi_fifo_quota.sv
// Shared-storage multi-queue FIFO: NUM_FIFOS linked-list queues threaded through one
// DEPTH-entry RAM, with a circular free list, per-queue counts and a per-queue quota.
module ll_multi_fifo_quota #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_FIFOS = 4,
  parameter int QUOTA     = DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [SEL_WIDTH-1:0]           push_sel,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           pop,
  input  logic [SEL_WIDTH-1:0]           pop_sel,
  output logic [WIDTH-1:0]               data_out,
  output logic [NUM_FIFOS-1:0]           empty,
  output logic                           full,
  output logic [NUM_FIFOS-1:0]           quota_full,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0]           free_count,
  output logic                           push_err,
  output logic                           pop_err
);

  logic [WIDTH-1:0]     mem_q  [DEPTH];
  logic [PTR_WIDTH-1:0] nxt_q  [DEPTH];
  logic [PTR_WIDTH-1:0] fl_q   [DEPTH];
  logic [PTR_WIDTH-1:0] head_q [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] head_d [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] tail_q [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] tail_d [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_FIFOS];
  logic [PTR_WIDTH:0]   fl_rd_q, fl_rd_d, fl_wr_q, fl_wr_d, fl_occ;
  logic                 push_err_q, push_err_d, pop_err_q, pop_err_d;
  logic                 push_sel_ok, pop_sel_ok, push_ok, pop_ok, same_q, nxt_we;
  logic [SEL_WIDTH-1:0] push_idx, pop_idx;
  logic [PTR_WIDTH-1:0] f_idx, h_idx;
  int                   occ_sum;

  // Out-of-range selects are steered to queue 0 for reads and rejected below.
  assign push_sel_ok = int'(push_sel) < NUM_FIFOS;
  assign pop_sel_ok  = int'(pop_sel) < NUM_FIFOS;
  assign push_idx    = push_sel_ok ? push_sel : '0;
  assign pop_idx     = pop_sel_ok ? pop_sel : '0;

  assign fl_occ     = fl_wr_q - fl_rd_q;
  assign free_count = CNT_WIDTH'(fl_occ);
  assign full       = (fl_occ == '0);
  assign f_idx      = fl_q[fl_rd_q[PTR_WIDTH-1:0]];
  assign h_idx      = head_q[pop_idx];

  assign push_ok = push & push_sel_ok & ~full & (cnt_q[push_idx] != CNT_WIDTH'(QUOTA));
  assign pop_ok  = pop & pop_sel_ok & (cnt_q[pop_idx] != '0);
  assign same_q  = pop_ok & (pop_idx == push_idx);
  assign nxt_we  = push_ok & (cnt_q[push_idx] != '0);

  assign data_out = (pop_sel_ok && cnt_q[pop_idx] != '0) ? mem_q[h_idx] : '0;
  assign push_err = push_err_q;
  assign pop_err  = pop_err_q;

  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      empty[i]                        = (cnt_q[i] == '0);
      quota_full[i]                   = (cnt_q[i] == CNT_WIDTH'(QUOTA));
      count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  // Pop is applied first so a same-queue push sees the decremented count and can override head.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    fl_rd_d    = fl_rd_q;
    fl_wr_d    = fl_wr_q;
    push_err_d = push & ~push_ok;
    pop_err_d  = pop & ~pop_ok;
    if (pop_ok) begin
      head_d[pop_idx] = nxt_q[h_idx];
      cnt_d[pop_idx]  = cnt_d[pop_idx] - CNT_WIDTH'(1);
      fl_wr_d         = fl_wr_q + (PTR_WIDTH + 1)'(1);
    end
    if (push_ok) begin
      if (cnt_q[push_idx] == '0 || (same_q && cnt_q[push_idx] == CNT_WIDTH'(1)))
        head_d[push_idx] = f_idx;
      tail_d[push_idx] = f_idx;
      cnt_d[push_idx]  = cnt_d[push_idx] + CNT_WIDTH'(1);
      fl_rd_d          = fl_rd_q + (PTR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_rd_q    <= '0;
      fl_wr_q    <= (PTR_WIDTH + 1)'(DEPTH);
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fl_q[i] <= PTR_WIDTH'(i);
      for (int i = 0; i < NUM_FIFOS; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      fl_rd_q    <= fl_rd_d;
      fl_wr_q    <= fl_wr_d;
      push_err_q <= push_err_d;
      pop_err_q  <= pop_err_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      if (pop_ok) fl_q[fl_wr_q[PTR_WIDTH-1:0]] <= h_idx;
    end
  end

  // Storage is not reset; only linked entries are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[f_idx] <= data_in;
    if (nxt_we) nxt_q[tail_q[push_idx]] <= f_idx;
  end

  always_comb begin
    occ_sum = int'(fl_occ);
    for (int i = 0; i < NUM_FIFOS; i++) occ_sum = occ_sum + int'(cnt_q[i]);
  end

  a_occupancy: assert property (@(posedge clk) disable iff (rst) occ_sum == DEPTH);

endmodule
